// File: rtl/axi_lite_slave_mem.sv
// -----------------------------------------------------------------------------
// axi_lite_slave_mem
// AXI4-Lite slave backed by a word-addressed memory array.
//   - Write side: AW and W are accepted independently (either order or the
//     same cycle). The first one to arrive is latched. The memory write commits
//     on the edge where the second one is accepted, and BVALID rises on that
//     edge. Only one write can be outstanding at a time.
//   - Read side: an AR handshake loads RDATA from the array and raises RVALID.
//     RDATA/RVALID then hold until RREADY is seen.
//   - Word index = ADDR[log2(MEM_WORDS)+1:2]. Other address bits are ignored,
//     so addresses alias modulo MEM_WORDS*4.
//   - wr_count / rd_count count completed B and R beats and wrap at 8 bits.
// Ports:
//   clk, reset (synchronous, active low)
//   AWADDR/AWVALID/AWREADY, WDATA/WVALID/WREADY, BVALID/BREADY
//   ARADDR/ARVALID/ARREADY, RDATA/RVALID/RREADY
//   wr_count, rd_count (8-bit completion counters)
// The array is not cleared by reset. A reset in the middle of a transaction
// discards any latched AW/W and any pending B/R response.
// -----------------------------------------------------------------------------
module axi_lite_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [7:0]            wr_count,
    output logic [7:0]            rd_count
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];

    logic                  aw_got_r;
    logic                  w_got_r;
    logic                  bvalid_r;
    logic                  rvalid_r;
    logic [IDX_W-1:0]      aw_idx_r;
    logic [DATA_WIDTH-1:0] w_data_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [7:0]            wr_count_r;
    logic [7:0]            rd_count_r;

    logic                  aw_ready_s;
    logic                  w_ready_s;
    logic                  ar_ready_s;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  b_hs_s;
    logic                  ar_hs_s;
    logic                  r_hs_s;
    logic                  commit_s;
    logic [IDX_W-1:0]      aw_idx_s;
    logic [IDX_W-1:0]      ar_idx_s;
    logic [IDX_W-1:0]      commit_idx_s;
    logic [DATA_WIDTH-1:0] commit_data_s;
    logic                  unused_addr_s;

    // Only the word-index bits of the addresses matter; fold the rest away
    assign unused_addr_s = ^{AWADDR, ARADDR};

    // Ready generation, handshake decode and write-commit operand selection
    always_comb begin
        aw_ready_s = reset & ~aw_got_r & ~bvalid_r;
        w_ready_s  = reset & ~w_got_r & ~bvalid_r;
        ar_ready_s = reset & ~rvalid_r;
        aw_hs_s    = AWVALID & aw_ready_s;
        w_hs_s     = WVALID & w_ready_s;
        b_hs_s     = bvalid_r & BREADY;
        ar_hs_s    = ARVALID & ar_ready_s;
        r_hs_s     = rvalid_r & RREADY;
        aw_idx_s   = AWADDR[IDX_W+1:2];
        ar_idx_s   = ARADDR[IDX_W+1:2];
        // Commit once both halves are in hand, whether latched earlier or
        // arriving on this edge. Both flags are never set at the same time,
        // so at least one live handshake is always part of a commit.
        commit_s   = (aw_hs_s | aw_got_r) & (w_hs_s | w_got_r);
        if (aw_got_r) begin
            commit_idx_s = aw_idx_r;
        end else begin
            commit_idx_s = aw_idx_s;
        end
        if (w_got_r) begin
            commit_data_s = w_data_r;
        end else begin
            commit_data_s = WDATA;
        end
    end

    // Write channel: AW/W latch flags, B response and write completion counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            aw_got_r   <= 1'b0;
            w_got_r    <= 1'b0;
            aw_idx_r   <= '0;
            w_data_r   <= '0;
            bvalid_r   <= 1'b0;
            wr_count_r <= 8'd0;
        end else begin
            if (commit_s) begin
                aw_got_r <= 1'b0;
                w_got_r  <= 1'b0;
                bvalid_r <= 1'b1;
            end else begin
                if (aw_hs_s) begin
                    aw_got_r <= 1'b1;
                    aw_idx_r <= aw_idx_s;
                end
                if (w_hs_s) begin
                    w_got_r  <= 1'b1;
                    w_data_r <= WDATA;
                end
            end
            // A commit needs BVALID low, so it never coincides with a B beat
            if (b_hs_s) begin
                bvalid_r   <= 1'b0;
                wr_count_r <= wr_count_r + 8'd1;
            end
        end
    end

    // Storage array: written only on a commit and left untouched by reset
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[commit_idx_s] <= commit_data_s;
        end
    end

    // Read channel: the array is sampled before any same-edge commit lands,
    // so a read that coincides with a write returns the old word
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_r    <= '0;
            rvalid_r   <= 1'b0;
            rd_count_r <= 8'd0;
        end else begin
            if (ar_hs_s) begin
                rdata_r  <= mem_r[ar_idx_s];
                rvalid_r <= 1'b1;
            end else if (r_hs_s) begin
                rvalid_r   <= 1'b0;
                rd_count_r <= rd_count_r + 8'd1;
            end
        end
    end

    assign AWREADY  = aw_ready_s;
    assign WREADY   = w_ready_s;
    assign ARREADY  = ar_ready_s;
    assign BVALID   = bvalid_r;
    assign RVALID   = rvalid_r;
    assign RDATA    = rdata_r;
    assign wr_count = wr_count_r;
    assign rd_count = rd_count_r;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_slave_mem
// Scoreboard bench for axi_lite_slave_mem. The driver issues transactions and
// pushes expected responses computed from a plain word-array model. A separate
// monitor pops these expectations and compares them on every B/R beat it sees.
// -----------------------------------------------------------------------------
module tb_axi_lite_slave_mem;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic          WVALID;
    logic          WREADY;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic          RVALID;
    logic          RREADY;
    logic [7:0]    wr_count;
    logic [7:0]    rd_count;

    axi_lite_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] model [MW];
    logic [31:0] rq [$];
    int          bq [$];
    int          n_wr = 0;
    int          n_rd = 0;
    bit          in_reset = 1'b1;
    int          rmode = 1;  // 0 hold low, 1 hold high, 2 random
    int          bmode = 1;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(MW));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response-ready driver
    initial begin
        BREADY = 1'b0;
        RREADY = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            BREADY = (bmode == 2) ? ($urandom_range(0, 1) == 1) : (bmode == 1);
            RREADY = (rmode == 2) ? ($urandom_range(0, 1) == 1) : (rmode == 1);
        end
    end

    // Monitor: scoreboard pops on every B/R beat plus R stall stability
    initial begin
        int          r_beats = 0;
        int          b_beats = 0;
        bit          r_stall = 1'b0;
        logic [31:0] r_hold = 32'd0;
        logic [31:0] exp_d;
        int          unused_b;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                r_beats = 0;
                b_beats = 0;
                r_stall = 1'b0;
            end else begin
                if (r_stall) begin
                    check("r_stall_valid", 32'(RVALID), 32'd1);
                    check("r_stall_data", RDATA, r_hold);
                end
                r_stall = RVALID && !RREADY;
                r_hold  = RDATA;
                if (RVALID && RREADY) begin
                    if (rq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_r: got RDATA 0x%08h expected no beat", RDATA);
                    end else begin
                        exp_d = rq.pop_front();
                        check("rdata", RDATA, exp_d);
                        check("rd_count_at_beat", 32'(rd_count), 32'(r_beats % 256));
                        r_beats++;
                    end
                end
                if (BVALID && BREADY) begin
                    if (bq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_b: got BVALID 1 expected no beat");
                    end else begin
                        unused_b = bq.pop_front();
                        check("wr_count_at_beat", 32'(wr_count), 32'(b_beats % 256));
                        b_beats++;
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] mdata, input int aw_dly, input int w_dly,
                            output int cycles);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit aw_f;
        bit w_f;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 60) begin
            if (!aw_done && cyc >= aw_dly) begin
                AWVALID = 1'b1;
                AWADDR  = addr;
            end else begin
                AWVALID = 1'b0;
                AWADDR  = $urandom;
            end
            if (!w_done && cyc >= w_dly) begin
                WVALID = 1'b1;
                WDATA  = data;
            end else begin
                WVALID = 1'b0;
                WDATA  = $urandom;
            end
            @(negedge clk);
            if (aw_done && !w_done) check("awready_while_aw_held", 32'(AWREADY), 32'd0);
            if (w_done && !aw_done) check("wready_while_w_held", 32'(WREADY), 32'd0);
            aw_f = AWVALID && AWREADY;
            w_f  = WVALID && WREADY;
            tick();
            if (aw_f) aw_done = 1'b1;
            if (w_f) w_done = 1'b1;
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        AWADDR  = $urandom;
        WDATA   = $urandom;
        cycles  = cyc;
        if (!(aw_done && w_done)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL write_timeout: got aw=%0d w=%0d expected both accepted", aw_done, w_done);
        end else begin
            model[widx(addr)] = mdata;
            bq.push_back(widx(addr));
            n_wr++;
        end
    endtask

    task automatic do_read(input logic [31:0] addr);
        bit f = 1'b0;
        int k = 0;
        ARADDR  = addr;
        ARVALID = 1'b1;
        while (!f && k < 60) begin
            @(negedge clk);
            f = ARREADY;
            tick();
            k++;
        end
        ARVALID = 1'b0;
        ARADDR  = $urandom;
        if (!f) begin
            n_cmp++;
            n_fail++;
            $display("FAIL read_timeout: got ARREADY 0 expected 1 within 60 cycles");
        end else begin
            rq.push_back(model[widx(addr)]);
            n_rd++;
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((rq.size() != 0 || bq.size() != 0 || RVALID || BVALID) && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got rq=%0d bq=%0d expected empty", rq.size(), bq.size());
        end
    endtask

    // Main stimulus
    initial begin
        int          cyc;
        int          base_wr;
        int          base_rd;
        logic [31:0] d;
        logic [31:0] a;
        reset   = 1'b0;
        AWADDR  = 32'd0;
        AWVALID = 1'b0;
        WDATA   = 32'd0;
        WVALID  = 1'b0;
        ARADDR  = 32'd0;
        ARVALID = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_wready", 32'(WREADY), 32'd0);
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        tick();
        reset    = 1'b1;
        in_reset = 1'b0;

        // Same-cycle AW+W, then read back
        do_write(32'h0000_2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, cyc);
        check("w029_cycles", 32'(cyc), 32'd1);
        check("w029_bvalid_lat", 32'(BVALID), 32'd1);
        tick();
        check("w029_wr_count", 32'(wr_count), 32'd1);
        do_read(32'h0000_2000);
        check("r029_rvalid_lat", 32'(RVALID), 32'd1);
        tick();
        check("r029_rd_count", 32'(rd_count), 32'd1);

        // Fill the remaining words so every later read has a known answer
        for (int i = 1; i < MW; i++) begin
            d = $urandom;
            do_write(32'(i * 4), d, d, 0, $urandom_range(0, 1), cyc);
        end
        drain();

        // AW three cycles ahead of W
        do_write(32'h0000_1004, 32'h1234_5678, 32'h1234_5678, 0, 3, cyc);
        check("w030_cycles", 32'(cyc), 32'd4);
        check("w030_bvalid", 32'(BVALID), 32'd1);
        do_read(32'h0000_1004);
        drain();

        // Read back-pressure
        rmode = 0;
        do_read(32'h0000_1000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_r_rvalid", 32'(RVALID), 32'd1);
            check("bp_r_arready", 32'(ARREADY), 32'd0);
            tick();
        end
        rmode = 1;
        drain();

        // Write back-pressure
        bmode = 0;
        do_write(32'h0000_3010, 32'hC0FF_EE00, 32'hC0FF_EE00, 0, 0, cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_b_bvalid", 32'(BVALID), 32'd1);
            check("bp_b_awready", 32'(AWREADY), 32'd0);
            check("bp_b_wready", 32'(WREADY), 32'd0);
            tick();
        end
        bmode = 1;
        drain();

        // Aliasing and same-edge read/write to one word
        do_write(32'h0000_0008, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 0, 0, cyc);
        drain();
        do_read(32'h0000_0108);
        drain();
        AWADDR  = 32'h0000_0008;
        WDATA   = 32'hA5A5_A5A5;
        ARADDR  = 32'h0000_0008;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        ARVALID = 1'b1;
        @(negedge clk);
        check("same_edge_awready", 32'(AWREADY), 32'd1);
        check("same_edge_wready", 32'(WREADY), 32'd1);
        check("same_edge_arready", 32'(ARREADY), 32'd1);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        rq.push_back(model[2]);
        n_rd++;
        model[2] = 32'hA5A5_A5A5;
        bq.push_back(2);
        n_wr++;
        drain();
        do_read(32'h0000_0008);
        drain();

        // Reset with AW latched and a read response pending
        rmode = 0;
        do_read(32'h0000_3000);
        AWADDR  = 32'h0000_2000;
        AWVALID = 1'b1;
        @(negedge clk);
        check("rst_mid_awready", 32'(AWREADY), 32'd1);
        tick();
        AWVALID  = 1'b0;
        reset    = 1'b0;
        in_reset = 1'b1;
        rq.delete();
        bq.delete();
        @(negedge clk);
        check("rst_mid_awready_low", 32'(AWREADY), 32'd0);
        check("rst_mid_arready_low", 32'(ARREADY), 32'd0);
        tick();
        check("rst_mid_rvalid", 32'(RVALID), 32'd0);
        check("rst_mid_bvalid", 32'(BVALID), 32'd0);
        check("rst_mid_wr_count", 32'(wr_count), 32'd0);
        check("rst_mid_rd_count", 32'(rd_count), 32'd0);
        check("rst_mid_rdata", RDATA, 32'd0);
        reset    = 1'b1;
        in_reset = 1'b0;
        rmode    = 1;
        n_wr     = 0;
        n_rd     = 0;
        @(negedge clk);
        check("post_rst_awready", 32'(AWREADY), 32'd1);
        check("post_rst_wready", 32'(WREADY), 32'd1);
        tick();
        do_read(32'h0000_2000);
        drain();

        // DMA-style copy: load source words, then read/write pairs
        for (int i = 0; i < 7; i++) begin
            d = $urandom;
            do_write(32'h0000_1100 + 32'(i * 4), d, d, 0, 0, cyc);
        end
        drain();
        base_wr = n_wr;
        base_rd = n_rd;
        for (int i = 0; i < 7; i++) begin
            do_read(32'h0000_1100 + 32'(i * 4));
            d = RDATA;
            do_write(32'h0000_2100 + 32'(i * 4), d,
                     model[widx(32'h0000_1100 + 32'(i * 4))], 0, 0, cyc);
        end
        drain();
        check("dma_rd_count", 32'(rd_count), 32'((base_rd + 7) % 256));
        check("dma_wr_count", 32'(wr_count), 32'((base_wr + 7) % 256));
        for (int i = 0; i < 7; i++) do_read(32'h0000_2100 + 32'(i * 4));
        drain();

        // Random traffic with random response back-pressure
        rmode = 2;
        bmode = 2;
        for (int i = 0; i < 600; i++) begin
            a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, d, $urandom_range(0, 3), $urandom_range(0, 3), cyc);
            end else begin
                do_read(a);
            end
        end
        rmode = 1;
        bmode = 1;
        drain();
        check("final_wr_count", 32'(wr_count), 32'(n_wr % 256));
        check("final_rd_count", 32'(rd_count), 32'(n_rd % 256));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
